mem_sweep_ctrl: RTL and testbench
=================================

# mem_sweep_ctrl

Parametrised memory sweep controller: the next generation of the board-level memory walker. It drives one read/write port of a single-port synchronous-read RAM, walking every address of a 2^ADDR_W-word space to fill it with a pattern, verify it, or both. The controller supports free-run and single-step (button-advanced) operation, and it counts mismatches. It sits between the board I/O (buttons, hex/LED display logic) and the memory block.

## Interface
- DATA_W, 16, memory word width; must be >= ADDR_W
- ADDR_W, 10, address width; the sweep covers 0 .. 2^ADDR_W-1
- SEED, 16'hA5C3, pattern XOR constant; truncated to DATA_W
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; starts a run when idle or done
- abort  in  1  single-cycle pulse; terminates a run and returns to IDLE
- op  in  2  operation, sampled on start: 00 FILL, 01 VERIFY, 10 FILL_VERIFY, 11 CLEAR
- step_mode  in  1  sampled on start; 1 = one address per next edge, 0 = free-run
- next  in  1  synchronous active-high level, already debounced; rising edge detected internally
- mem_addr  out  ADDR_W  memory address
- mem_wr_en  out  1  memory write enable
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_addr is presented
- busy  out  1  run in progress
- done  out  1  last run completed; held until the next start
- pass  out  1  done and err_count == 0
- err_count  out  ADDR_W+1  number of mismatches in the last verify phase
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
- cur_addr  out  ADDR_W  address currently being operated on, for display

## Operation
- Pattern: P(a) = zero_extend(a, DATA_W) XOR SEED. CLEAR writes 0.
- States are IDLE, WRITE, RD_ISSUE, RD_CHECK, HOLD, DONE.
- IDLE or DONE, on start:
  - latch op and step_mode
  - set addr to 0
  - clear err_count, first_err_addr and done
  - go to WRITE if op is FILL, FILL_VERIFY or CLEAR; go to RD_ISSUE if op is VERIFY
- WRITE:
  - drive mem_wr_en=1, mem_addr=addr, mem_wr_data=P(addr) (0 for CLEAR)
  - then go to HOLD if step_mode, otherwise advance
- RD_ISSUE: drive mem_addr=addr with mem_wr_en=0, then go to RD_CHECK.
- RD_CHECK:
  - compare mem_rd_data with P(addr)
  - on mismatch, increment err_count; if err_count was 0, load first_err_addr=addr
  - then go to HOLD if step_mode, otherwise advance
- HOLD: wait for a rising edge of next, then advance. Edges on next in any other state are ignored.
- Advance:
  - if addr < 2^ADDR_W-1: increment addr and re-enter the current phase (WRITE or RD_ISSUE)
  - at the last address of the write phase of FILL_VERIFY: set addr to 0 and enter RD_ISSUE
  - otherwise go to DONE
- DONE: done=1, busy=0.
- abort in any state other than IDLE:
  - go to IDLE next cycle; done stays 0
  - err_count and first_err_addr keep their partial values
- abort has priority over start and next in the same cycle.
- start while busy is ignored.
- busy=1 in WRITE, RD_ISSUE, RD_CHECK and HOLD.
- In HOLD, mem_addr stays at the last address. mem_wr_en=0 outside WRITE.
- err_count never overflows, because there are at most 2^ADDR_W mismatches.

## Timing
- Reset (asynchronous, reset_n=0): state IDLE and every output 0, including mem_wr_en, mem_addr, err_count, first_err_addr, done, pass and busy. The internal next-edge register is also cleared.
- Start latency: start in cycle N puts the first WRITE or RD_ISSUE in cycle N+1, and busy rises in N+1.
- Free-run FILL or CLEAR: 2^ADDR_W cycles of consecutive writes. done=1 in the cycle after the last write.
- Free-run VERIFY: 2 cycles per address (2^(ADDR_W+1) total). err_count updates at the clock edge ending RD_CHECK.
- FILL_VERIFY: the verify read of address 0 is issued in the cycle immediately after the write of the last address.
- Step mode:
  - a next rising edge sampled in HOLD at cycle M puts the next operation in cycle M+1
  - the edge detector requires next=0 for at least one cycle between steps
- pass is combinational from done and err_count.
- cur_addr = addr register.

## Test plan
- ADDR_W=4: FILL, free-run. Expect 16 writes in 16 consecutive cycles, address 0 writes 16'hA5C3 and address 15 writes 16'hA5CC, then done=1, busy=0.
- FILL then VERIFY on a clean model. Expect err_count=0 and pass=1. Corrupt address 9 before the VERIFY. Expect err_count=1, first_err_addr=9, pass=0.
- Corrupt addresses 3 and 12, then run VERIFY. Expect err_count=2 and first_err_addr=3.
- FILL_VERIFY with step_mode=1. Expect exactly one operation per next rising edge. Holding next high produces no further steps. Expect done after 32 edges.
- abort during the VERIFY phase at address 7. Expect IDLE next cycle, done=0, mem_wr_en=0. A start in the same cycle as abort is ignored.
- reset_n asserted mid-FILL, asynchronously and off a clock edge. Expect all outputs 0 immediately. After release, a new start begins at address 0.

Source files
------------

// File: rtl/mem_sweep_if.sv
// Memory-side bus of the sweep controller.
// Master drives address/write; slave returns synchronous read data.
interface mem_sweep_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/mem_sweep_ctrl.sv
// Memory sweep controller: fill, verify or clear a RAM address space,
// free-running or stepped by a debounced button, counting mismatches.
module mem_sweep_ctrl #(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 10,
    parameter logic [15:0] SEED   = 16'hA5C3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op,
    input  logic              step_mode,
    input  logic              next,
    mem_sweep_if.master       mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] cur_addr
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CHECK,
        HOLD,
        DONE
    } state_t;

    localparam logic [1:0] OP_FILL   = 2'b00;
    localparam logic [1:0] OP_VERIFY = 2'b01;
    localparam logic [1:0] OP_FV     = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [DATA_W-1:0] SEED_D = DATA_W'(SEED);

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED_D;
    endfunction

    state_t            state;
    logic [1:0]        op_q;
    logic              step_q;
    logic              rd_phase;
    logic              next_q;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    logic              next_rise;
    logic              mismatch;
    state_t            adv_state;
    logic [ADDR_W-1:0] adv_addr;
    logic              adv_rd;
    logic [DATA_W-1:0] adv_data;

    assign next_rise       = next & ~next_q;
    assign mismatch        = mem.mem_rd_data != pat(addr);
    assign mem.mem_addr    = addr;
    assign mem.mem_wr_en   = wr_en;
    assign mem.mem_wr_data = wr_data;
    assign cur_addr        = addr;
    assign pass            = done && (err_count == '0);

    // Where the sweep goes after finishing the current address.
    always_comb begin
        adv_state = rd_phase ? RD_ISSUE : WRITE;
        adv_addr  = addr + 1'b1;
        adv_rd    = rd_phase;
        if (&addr) begin
            if (!rd_phase && op_q == OP_FV) begin
                adv_state = RD_ISSUE;
                adv_addr  = '0;
                adv_rd    = 1'b1;
            end else begin
                adv_state = DONE;
                adv_addr  = addr;
            end
        end
        adv_data = (op_q == OP_CLEAR) ? '0 : pat(adv_addr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            op_q           <= OP_FILL;
            step_q         <= 1'b0;
            rd_phase       <= 1'b0;
            next_q         <= 1'b0;
            addr           <= '0;
            wr_en          <= 1'b0;
            wr_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            next_q <= next;
            wr_en  <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            op_q           <= op;
                            step_q         <= step_mode;
                            addr           <= '0;
                            err_count      <= '0;
                            first_err_addr <= '0;
                            done           <= 1'b0;
                            busy           <= 1'b1;
                            if (op == OP_VERIFY) begin
                                state    <= RD_ISSUE;
                                rd_phase <= 1'b1;
                            end else begin
                                state    <= WRITE;
                                rd_phase <= 1'b0;
                                wr_en    <= 1'b1;
                                wr_data  <= (op == OP_CLEAR) ? '0 : SEED_D;
                            end
                        end
                    end
                    RD_ISSUE: state <= RD_CHECK;
                    WRITE, RD_CHECK, HOLD: begin
                        if (state == RD_CHECK && mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (err_count == '0)
                                first_err_addr <= addr;
                        end
                        if (state != HOLD && step_q) begin
                            state <= HOLD;
                        end else if (state != HOLD || next_rise) begin
                            state    <= adv_state;
                            addr     <= adv_addr;
                            rd_phase <= adv_rd;
                            wr_en    <= (adv_state == WRITE);
                            wr_data  <= adv_data;
                            if (adv_state == DONE) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a 16-word RAM model
// and a read-side corruption mask.
module tb_mem_sweep_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          step_mode = 1'b0;
    logic          next = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] cur_addr;

    logic [DW-1:0] ram [16];
    logic [15:0]   bad_mask = '0;

    int total = 0;
    int bad = 0;

    mem_sweep_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_sweep_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SEED(16'hA5C3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .op            (op),
        .step_mode     (step_mode),
        .next          (next),
        .mem           (bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .cur_addr      (cur_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr_en)
            ram[bus.mem_addr] <= bus.mem_wr_data;
        bus.mem_rd_data <= ram[bus.mem_addr] ^
            (bad_mask[bus.mem_addr] ? 16'h0040 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] o, input logic s);
        @(negedge clk);
        op        = o;
        step_mode = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        bus.mem_rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_wren", 32'(bus.mem_wr_en), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_first", 32'(first_err_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free-run FILL: 16 back-to-back writes
        do_start(2'b00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("fill_wren", 32'(bus.mem_wr_en), 1);
            chk("fill_addr", 32'(bus.mem_addr), 32'(i));
            chk("fill_data", 32'(bus.mem_wr_data), 32'(16'hA5C3 ^ 16'(i)));
            chk("fill_busy", 32'(busy), 1);
            tick();
        end
        chk("fill_done", 32'(done), 1);
        chk("fill_busy0", 32'(busy), 0);
        chk("fill_wren0", 32'(bus.mem_wr_en), 0);
        chk("fill_ram15", 32'(ram[15]), 32'h0000A5CC);

        // Clean VERIFY: two cycles per address
        do_start(2'b01, 1'b0);
        chk("ver_wren", 32'(bus.mem_wr_en), 0);
        wait_done(100, n);
        chk("ver_cycles", 32'(n), 32);
        chk("ver_done", 32'(done), 1);
        chk("ver_err", 32'(err_count), 0);
        chk("ver_pass", 32'(pass), 1);

        bad_mask = 16'h0200;
        do_start(2'b01, 1'b0);
        wait_done(100, n);
        chk("ver9_done", 32'(done), 1);
        chk("ver9_err", 32'(err_count), 1);
        chk("ver9_first", 32'(first_err_addr), 9);
        chk("ver9_pass", 32'(pass), 0);

        bad_mask = 16'h1008;
        do_start(2'b01, 1'b0);
        wait_done(100, n);
        chk("ver2_done", 32'(done), 1);
        chk("ver2_err", 32'(err_count), 2);
        chk("ver2_first", 32'(first_err_addr), 3);
        bad_mask = '0;

        // Stepped FILL_VERIFY: one operation per next rising edge
        do_start(2'b10, 1'b1);
        chk("st_w0", 32'(bus.mem_wr_en), 1);
        tick();
        tick();
        chk("st_hold_wren", 32'(bus.mem_wr_en), 0);
        chk("st_hold_addr", 32'(bus.mem_addr), 0);
        for (int k = 1; k <= 32; k++) begin
            next = 1'b1;
            tick();
            if (k < 16) begin
                chk("st_wr_en", 32'(bus.mem_wr_en), 1);
                chk("st_wr_addr", 32'(bus.mem_addr), 32'(k));
            end else if (k < 32) begin
                chk("st_rd_en", 32'(bus.mem_wr_en), 0);
                chk("st_rd_addr", 32'(bus.mem_addr), 32'(k - 16));
            end else begin
                chk("st_done", 32'(done), 1);
            end
            tick();
            tick();
            if (k < 32) begin
                chk("st_nostep", 32'(cur_addr), 32'(k < 16 ? k : k - 16));
                chk("st_busy", 32'(busy), 1);
                chk("st_idle_wr", 32'(bus.mem_wr_en), 0);
            end
            next = 1'b0;
            tick();
        end
        chk("st_done_hold", 32'(done), 1);
        chk("st_err", 32'(err_count), 0);
        chk("st_pass", 32'(pass), 1);

        // Abort mid-VERIFY, with a competing start
        do_start(2'b01, 1'b0);
        n = 0;
        while (cur_addr != 4'd7 && n < 40) begin
            tick();
            n++;
        end
        chk("ab_reach7", 32'(cur_addr), 7);
        abort = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_wren", 32'(bus.mem_wr_en), 0);
        tick();
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_idle_wren", 32'(bus.mem_wr_en), 0);

        // Asynchronous reset mid-FILL
        do_start(2'b00, 1'b0);
        repeat (5) tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_wren", 32'(bus.mem_wr_en), 0);
        chk("ar_addr", 32'(bus.mem_addr), 0);
        chk("ar_data", 32'(bus.mem_wr_data), 0);
        chk("ar_done", 32'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_start(2'b00, 1'b0);
        chk("ar_re_addr", 32'(bus.mem_addr), 0);
        chk("ar_re_wren", 32'(bus.mem_wr_en), 1);
        chk("ar_re_data", 32'(bus.mem_wr_data), 32'h0000A5C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
